// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with shadowed divisor/high-time settings.
// Optional phase-restart input enabled by defining CLKDIV_SYNC_EN.
module clk_div_prog #(
    parameter int CNT_W        = 16,
    parameter int DIV_DEFAULT  = 50,
    parameter int HIGH_DEFAULT = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic [CNT_W-1:0] high_val,
    input  logic             load,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic             pend,
    output logic [CNT_W-1:0] count,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(HIGH_DEFAULT);
    localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);

    logic [CNT_W-1:0] div_a, high_a, div_s, high_s;
    logic [CNT_W-1:0] count_n, div_a_n, high_a_n, div_s_n, high_s_n;
    logic             pend_n, tick_n, clk_out_n;
    logic [CNT_W-1:0] ld_div;
    logic             wrap, sync_hit, restart;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    // Divisors below 2 would make the counter wrap every cycle with no low phase.
    assign ld_div  = (div_val < DIV_MIN) ? DIV_MIN : div_val;
    assign wrap    = en && (count == (div_a - CNT_W'(1)));
    assign restart = sync_hit || wrap;

    always_comb begin
        count_n  = count;
        tick_n   = 1'b0;
        pend_n   = pend;
        div_a_n  = div_a;
        high_a_n = high_a;
        div_s_n  = div_s;
        high_s_n = high_s;

        if (load) begin
            div_s_n  = ld_div;
            high_s_n = high_val;
            pend_n   = 1'b1;
        end

        if (sync_hit) begin
            count_n = '0;
        end else if (wrap) begin
            count_n = '0;
            tick_n  = 1'b1;
        end else if (en) begin
            count_n = count + CNT_W'(1);
        end

        // A load coinciding with a period boundary bypasses the shadow.
        if (restart) begin
            if (load) begin
                div_a_n  = ld_div;
                high_a_n = high_val;
                pend_n   = 1'b0;
            end else if (pend) begin
                div_a_n  = div_s;
                high_a_n = high_s;
                pend_n   = 1'b0;
            end
        end

        clk_out_n = (count_n < high_a_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            tick    <= 1'b0;
            pend    <= 1'b0;
            div_a   <= DIV_RST;
            high_a  <= HIGH_RST;
            div_s   <= DIV_RST;
            high_s  <= HIGH_RST;
            clk_out <= (HIGH_DEFAULT != 0);
        end else begin
            count   <= count_n;
            tick    <= tick_n;
            pend    <= pend_n;
            div_a   <= div_a_n;
            high_a  <= high_a_n;
            div_s   <= div_s_n;
            high_s  <= high_s_n;
            clk_out <= clk_out_n;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: segment table plus hand-written corner sequences,
// compared cycle-by-cycle against a behavioural model through a scoreboard queue.
module tb_clk_div_prog;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, en, load;
    logic [W-1:0] div_val, high_val;
`ifdef CLKDIV_SYNC_EN
    logic         sync;
`endif
    logic         pend, clk_out, tick;
    logic [W-1:0] count;

    always #5 clk = ~clk;

    clk_div_prog #(.CNT_W(W), .DIV_DEFAULT(50), .HIGH_DEFAULT(25)) dut (
        .clk(clk), .rst(rst), .en(en), .div_val(div_val), .high_val(high_val), .load(load),
`ifdef CLKDIV_SYNC_EN
        .sync(sync),
`endif
        .pend(pend), .count(count), .clk_out(clk_out), .tick(tick)
    );

    typedef struct {
        int count;
        bit clk_out;
        bit tick;
        bit pend;
    } exp_t;

    typedef struct {
        bit r;
        bit e;
        bit l;
        int dv;
        int hv;
        int n;
    } seg_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int m_count, m_div, m_high, m_sdiv, m_shigh;
    bit m_pend, m_clk, m_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit l, input bit s,
                              input int dv, input int hv);
        int ld;
        bit at_end, restart_now;
        ld = (dv < 2) ? 2 : dv;
        if (r) begin
            m_count = 0; m_tick = 0; m_pend = 0;
            m_div = 50; m_high = 25; m_sdiv = 50; m_shigh = 25;
        end else begin
            at_end      = e && (m_count == m_div - 1);
            restart_now = s || at_end;
            m_tick      = !s && at_end;
            if (restart_now) m_count = 0;
            else if (e)      m_count = m_count + 1;
            if (restart_now && l) begin
                m_div = ld; m_high = hv; m_pend = 0;
            end else if (restart_now && m_pend) begin
                m_div = m_sdiv; m_high = m_shigh; m_pend = 0;
                if (l) begin m_sdiv = ld; m_shigh = hv; m_pend = 1; end
            end else if (l) begin
                m_sdiv = ld; m_shigh = hv; m_pend = 1;
            end
        end
        m_clk = (m_count < m_high);
    endtask

    task automatic step(input bit r, input bit e, input bit l, input bit s,
                        input int dv, input int hv);
        exp_t x;
        rst = r; en = e; load = l;
        div_val = W'(dv); high_val = W'(hv);
`ifdef CLKDIV_SYNC_EN
        sync = s;
`endif
        model_step(r, e, l, s, dv, hv);
        x.count = m_count; x.clk_out = m_clk; x.tick = m_tick; x.pend = m_pend;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("count",   32'(count),   32'(x.count));
        check("clk_out", 32'(clk_out), 32'(x.clk_out));
        check("tick",    32'(tick),    32'(x.tick));
        check("pend",    32'(pend),    32'(x.pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
    endtask

    task automatic run_until(input int t);
        for (int i = 0; i < 200 && m_count != t; i++) step(0, 1, 0, 0, 0, 0);
        check("reach_count", 32'(count), 32'(t));
    endtask

    task automatic wait_applied();
        for (int i = 0; i < 200 && m_pend; i++) step(0, 1, 0, 0, 0, 0);
        check("applied_pend", 32'(pend), 32'(0));
    endtask

    seg_t tbl[11];

    initial begin
        tbl[0]  = '{r:1, e:0, l:0, dv:0, hv:0, n:2};
        tbl[1]  = '{r:0, e:1, l:0, dv:0, hv:0, n:110};
        tbl[2]  = '{r:0, e:1, l:1, dv:4, hv:1, n:1};
        tbl[3]  = '{r:0, e:1, l:0, dv:0, hv:0, n:60};
        tbl[4]  = '{r:0, e:1, l:1, dv:1, hv:1, n:12};
        tbl[5]  = '{r:0, e:1, l:1, dv:3, hv:0, n:20};
        tbl[6]  = '{r:0, e:1, l:1, dv:8, hv:3, n:1};
        tbl[7]  = '{r:0, e:1, l:1, dv:6, hv:2, n:30};
        tbl[8]  = '{r:0, e:0, l:1, dv:9, hv:4, n:5};
        tbl[9]  = '{r:0, e:1, l:0, dv:0, hv:0, n:30};
        tbl[10] = '{r:0, e:1, l:1, dv:5, hv:7, n:25};

        rst = 1; en = 0; load = 0; div_val = '0; high_val = '0;
`ifdef CLKDIV_SYNC_EN
        sync = 0;
`endif

        foreach (tbl[i])
            for (int k = 0; k < tbl[i].n; k++)
                step(tbl[i].r, tbl[i].e, tbl[i].l && (k == 0), 1'b0, tbl[i].dv, tbl[i].hv);

        // defaults after reset, then a load mid-period waits for the wrap
        step(1, 0, 0, 0, 0, 0);
        check("rst_count", 32'(count), 0);
        check("rst_clk",   32'(clk_out), 1);
        check("rst_tick",  32'(tick), 0);
        check("rst_pend",  32'(pend), 0);
        run_until(10);
        step(0, 1, 1, 0, 4, 1);
        check("load_pend", 32'(pend), 1);
        run_until(49);
        check("pend_before_wrap", 32'(pend), 1);
        step(0, 1, 0, 0, 0, 0);
        check("wrap_count", 32'(count), 0);
        check("wrap_tick",  32'(tick), 1);
        check("wrap_pend",  32'(pend), 0);
        check("wrap_clk",   32'(clk_out), 1);
        for (int i = 1; i <= 3; i++) begin
            step(0, 1, 0, 0, 0, 0);
            check("div4_clk_low", 32'(clk_out), 0);
            check("div4_count",   32'(count), 32'(i));
        end
        step(0, 1, 0, 0, 0, 0);
        check("div4_tick", 32'(tick), 1);
        check("div4_clk",  32'(clk_out), 1);

        // divisor clamp and high-time extremes
        step(0, 1, 1, 0, 1, 1);
        wait_applied();
        run_until(0);
        step(0, 1, 0, 0, 0, 0);
        check("div2_clk_a", 32'(clk_out), 0);
        check("div2_cnt_a", 32'(count), 1);
        step(0, 1, 0, 0, 0, 0);
        check("div2_clk_b", 32'(clk_out), 1);
        check("div2_cnt_b", 32'(count), 0);
        step(0, 1, 1, 0, 2, 0);
        wait_applied();
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0, 0, 0);
            check("high0_clk", 32'(clk_out), 0);
        end
        step(0, 1, 1, 0, 5, 7);
        wait_applied();
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 0, 0);
            check("high_ge_div_clk", 32'(clk_out), 1);
        end

        // two loads before the wrap: last one wins; then a load in the wrap cycle
        step(0, 1, 1, 0, 8, 3);
        step(0, 1, 1, 0, 6, 2);
        wait_applied();
        run(6);
        check("div6_count", 32'(count), 0);
        check("div6_tick",  32'(tick), 1);
        run_until(5);
        step(0, 1, 1, 0, 4, 1);
        check("wrapload_count", 32'(count), 0);
        check("wrapload_tick",  32'(tick), 1);
        check("wrapload_pend",  32'(pend), 0);
        check("wrapload_clk",   32'(clk_out), 1);
        run(4);
        check("wrapload_period", 32'(tick), 1);

        // enable low holds everything; reset drops a pending shadow
        step(1, 0, 0, 0, 0, 0);
        run_until(30);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0, 0);
            check("hold_count", 32'(count), 30);
            check("hold_clk",   32'(clk_out), 0);
            check("hold_tick",  32'(tick), 0);
        end
        step(0, 1, 0, 0, 0, 0);
        check("resume_count", 32'(count), 31);
        step(1, 0, 0, 0, 0, 0);
        run_until(29);
        step(0, 1, 1, 0, 4, 1);
        check("pre_rst_pend", 32'(pend), 1);
        step(1, 1, 0, 0, 0, 0);
        check("rst_mid_pend",  32'(pend), 0);
        check("rst_mid_count", 32'(count), 0);
        check("rst_mid_clk",   32'(clk_out), 1);
        run(50);
        check("default_period_tick", 32'(tick), 1);
        check("default_period_cnt",  32'(count), 0);

`ifdef CLKDIV_SYNC_EN
        step(1, 0, 0, 0, 0, 0);
        run_until(37);
        step(0, 1, 0, 1, 0, 0);
        check("sync_count", 32'(count), 0);
        check("sync_clk",   32'(clk_out), 1);
        check("sync_tick",  32'(tick), 0);
        step(0, 1, 1, 0, 4, 2);
        step(0, 0, 0, 1, 0, 0);
        check("sync_pend",  32'(pend), 0);
        check("sync_count2", 32'(count), 0);
        step(0, 1, 0, 0, 0, 0);
        check("sync_new_clk1", 32'(clk_out), 1);
        step(0, 1, 0, 0, 0, 0);
        check("sync_new_clk2", 32'(clk_out), 0);
        run(2);
        check("sync_new_tick", 32'(tick), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
